// File: rtl/z80_bus_master_pkg.sv
// z80_bus_master_pkg
// Shared definitions for the Z80 bus master: bus-cycle state encoding, refresh
// counter width and the refresh-address helper.
// No ports (package).

package z80_bus_master_pkg;

   localparam int unsigned R_WIDTH = 7;

   typedef enum logic [2:0] {
      st_idle,
      st_t1,
      st_t2,
      st_tw,
      st_t3,
      st_t4
   } bus_state_t;

   // Refresh address: I register on the high byte, bit 7 forced low, R[6:0] below.
   function automatic logic [15:0] refresh_addr(input logic [7:0]         i_val,
                                                input logic [R_WIDTH-1:0] r_val);
      return {i_val, 1'b0, r_val};
   endfunction

endpackage

// File: rtl/z80_bus_master_delay.sv
// strobe_delay
// DELAY-stage shift register for the board-style delayed bus strobes.
// Every stage presets to all-ones (strobes inactive) on reset.
// Ports:
//   clk    in   1      clock
//   reset  in   1      asynchronous active-high reset
//   din    in   WIDTH  registered strobes to delay
//   dout   out  WIDTH  strobes delayed DELAY clocks

module strobe_delay #(
   parameter int unsigned DELAY = 1,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe [DELAY];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DELAY; i++) begin
            pipe[i] <= '1;
         end
      end else begin
         pipe[0] <= din;
         for (int unsigned i = 1; i < DELAY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign dout = pipe[DELAY-1];

endmodule

// File: rtl/z80_bus_master.sv
// z80_bus_master
// Z80-timed memory-cycle initiator. Converts a req/ack transaction into an
// opcode fetch (M1 + refresh), memory read or memory write bus cycle, one
// T-state per clock. All outputs are registered.
// Ports:
//   clk, reset              clock; async active-high reset
//   req, we, m1             request, write select, opcode-fetch select
//   addr_in, wdata, i_reg   transaction address, write data, refresh high byte
//   nwait                   active-low wait, sampled at end of T2 / each TW
//   data_in                 bus read data
//   ack, busy, rdata        completion pulse, cycle in progress, read data
//   addr, data_out, data_oe bus address, write data, data drive enable
//   nmreq nrd nwr nm1 nrfsh active-low strobes
//   nmreqd nrdd nrfshd      nmreq/nrd/nrfsh delayed DELAY clocks

module z80_bus_master
   import z80_bus_master_pkg::*;
#(
   parameter int unsigned DELAY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic        m1,
   input  logic [15:0] addr_in,
   input  logic [7:0]  wdata,
   input  logic [7:0]  i_reg,
   input  logic        nwait,
   output logic        ack,
   output logic        busy,
   output logic [7:0]  rdata,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        nmreq,
   output logic        nrd,
   output logic        nwr,
   output logic        nm1,
   output logic        nrfsh,
   output logic        nmreqd,
   output logic        nrdd,
   output logic        nrfshd,
   input  logic [7:0]  data_in
);

   bus_state_t         state_q, state_d;
   logic               is_write_q, is_write_d;
   logic               is_fetch_q, is_fetch_d;
   logic [R_WIDTH-1:0] r_q, r_d;
   logic               ack_q, ack_d;
   logic               busy_q, busy_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [15:0]        addr_q, addr_d;
   logic [7:0]         data_out_q, data_out_d;
   logic               data_oe_q, data_oe_d;
   logic               nmreq_q, nmreq_d;
   logic               nrd_q, nrd_d;
   logic               nwr_q, nwr_d;
   logic               nm1_q, nm1_d;
   logic               nrfsh_q, nrfsh_d;
   logic               req_write;
   logic [2:0]         dly;

   // A fetch request wins over we.
   assign req_write = we & ~m1;

   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      is_fetch_d = is_fetch_q;
      r_d        = r_q;
      ack_d      = 1'b0;
      rdata_d    = rdata_q;
      addr_d     = addr_q;
      data_out_d = data_out_q;
      data_oe_d  = data_oe_q;
      nmreq_d    = nmreq_q;
      nrd_d      = nrd_q;
      nwr_d      = nwr_q;
      nm1_d      = nm1_q;
      nrfsh_d    = nrfsh_q;

      unique case (state_q)
         st_idle: begin
            if (req) begin
               state_d    = st_t1;
               is_write_d = req_write;
               is_fetch_d = m1;
               addr_d     = addr_in;
               nmreq_d    = 1'b0;
               nrd_d      = req_write;
               nm1_d      = ~m1;
               data_oe_d  = req_write;
               if (req_write) begin
                  data_out_d = wdata;
               end
            end
         end
         st_t1: begin
            state_d = st_t2;
            if (is_write_q) begin
               nwr_d = 1'b0;
            end
         end
         st_t2, st_tw: begin
            if (!nwait) begin
               state_d = st_tw;
            end else begin
               state_d = st_t3;
               // Fetch data is taken here; T3/T4 become the refresh slot.
               if (is_fetch_q) begin
                  rdata_d = data_in;
                  nrd_d   = 1'b1;
                  nm1_d   = 1'b1;
                  nrfsh_d = 1'b0;
                  addr_d  = refresh_addr(i_reg, r_q);
               end
            end
         end
         st_t3: begin
            if (is_fetch_q) begin
               state_d = st_t4;
               nmreq_d = 1'b1;
            end else begin
               state_d = st_idle;
               if (!is_write_q) begin
                  rdata_d = data_in;
               end
               nmreq_d   = 1'b1;
               nrd_d     = 1'b1;
               nwr_d     = 1'b1;
               data_oe_d = 1'b0;
               ack_d     = 1'b1;
            end
         end
         st_t4: begin
            state_d = st_idle;
            nrfsh_d = 1'b1;
            ack_d   = 1'b1;
            r_d     = r_q + R_WIDTH'(1);
         end
         default: begin
            state_d = st_idle;
         end
      endcase

      busy_d = (state_d != st_idle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= st_idle;
         is_write_q <= 1'b0;
         is_fetch_q <= 1'b0;
         r_q        <= '0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         rdata_q    <= '0;
         addr_q     <= '0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
         nmreq_q    <= 1'b1;
         nrd_q      <= 1'b1;
         nwr_q      <= 1'b1;
         nm1_q      <= 1'b1;
         nrfsh_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         is_fetch_q <= is_fetch_d;
         r_q        <= r_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         rdata_q    <= rdata_d;
         addr_q     <= addr_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         nmreq_q    <= nmreq_d;
         nrd_q      <= nrd_d;
         nwr_q      <= nwr_d;
         nm1_q      <= nm1_d;
         nrfsh_q    <= nrfsh_d;
      end
   end

   strobe_delay #(
      .DELAY (DELAY),
      .WIDTH (3)
   ) u_strobe_delay (
      .clk   (clk),
      .reset (reset),
      .din   ({nmreq_q, nrd_q, nrfsh_q}),
      .dout  (dly)
   );

   assign ack      = ack_q;
   assign busy     = busy_q;
   assign rdata    = rdata_q;
   assign addr     = addr_q;
   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
   assign nmreq    = nmreq_q;
   assign nrd      = nrd_q;
   assign nwr      = nwr_q;
   assign nm1      = nm1_q;
   assign nrfsh    = nrfsh_q;
   assign nmreqd   = dly[2];
   assign nrdd     = dly[1];
   assign nrfshd   = dly[0];

endmodule

// File: tb/tb_z80_bus_master.sv
module tb_z80_bus_master;

   localparam int unsigned DLY = 2;
   localparam int OP_READ  = 0;
   localparam int OP_WRITE = 1;
   localparam int OP_FETCH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we, m1, nwait;
   logic [15:0] addr_in;
   logic [7:0]  wdata, i_reg, data_in;
   logic        ack, busy;
   logic [7:0]  rdata, data_out;
   logic [15:0] addr;
   logic        data_oe, nmreq, nrd, nwr, nm1, nrfsh, nmreqd, nrdd, nrfshd;

   z80_bus_master #(
      .DELAY (DLY)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .m1       (m1),
      .addr_in  (addr_in),
      .wdata    (wdata),
      .i_reg    (i_reg),
      .nwait    (nwait),
      .ack      (ack),
      .busy     (busy),
      .rdata    (rdata),
      .addr     (addr),
      .data_out (data_out),
      .data_oe  (data_oe),
      .nmreq    (nmreq),
      .nrd      (nrd),
      .nwr      (nwr),
      .nm1      (nm1),
      .nrfsh    (nrfsh),
      .nmreqd   (nmreqd),
      .nrdd     (nrdd),
      .nrfshd   (nrfshd),
      .data_in  (data_in)
   );

   always #5 clk = ~clk;

   // One expected transaction: stimulus plus the response the spec predicts.
   typedef struct {
      int          op;
      logic [15:0] a;
      logic [7:0]  wd;
      logic [7:0]  di;
      logic [7:0]  iv;
      int          nw;
      int          acc;  // cycle number of T1
      logic [7:0]  rd;   // rdata expected at ack
      logic [15:0] ra;   // refresh address (fetch only)
   } txn_t;

   txn_t       sbq[$];
   logic [2:0] hist[$];   // expected {nmreq,nrd,nrfsh} of past cycles
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic       mon_en = 1'b0;
   logic [6:0] model_r;
   logic [7:0] model_rdata;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: derives expected bus activity from the transaction at the queue head.
   task automatic mon_cycle();
      logic [7:0]  exp_s, got_s;
      logic [2:0]  exp_d;
      logic        chk_a, chk_wd;
      logic [15:0] ea;
      int          p, lastp;
      txn_t        t;
      exp_s  = 8'b0011_1110;  // {ack,busy,nmreq,nrd,nwr,nm1,nrfsh,data_oe} when idle
      chk_a  = 1'b0;
      chk_wd = 1'b0;
      ea     = '0;
      if (sbq.size() > 0 && cyc >= sbq[0].acc) begin
         t     = sbq[0];
         p     = cyc - t.acc;
         lastp = (t.op == OP_FETCH) ? t.nw + 3 : t.nw + 2;
         if (p <= lastp) begin
            exp_s[6] = 1'b1;
            chk_a    = 1'b1;
            ea       = t.a;
            if (t.op == OP_READ) begin
               exp_s[5] = 1'b0;
               exp_s[4] = 1'b0;
            end else if (t.op == OP_WRITE) begin
               exp_s[5] = 1'b0;
               exp_s[3] = (p < 1);
               exp_s[0] = 1'b1;
               chk_wd   = 1'b1;
            end else begin
               exp_s[5] = (p >= t.nw + 3);
               exp_s[4] = (p > t.nw + 1);
               exp_s[2] = (p > t.nw + 1);
               exp_s[1] = !(p >= t.nw + 2);
               if (p >= t.nw + 2) ea = t.ra;
            end
         end else begin
            exp_s[7] = 1'b1;
            chk("rdata_at_ack", 32'(rdata), 32'(t.rd));
            void'(sbq.pop_front());
         end
      end
      got_s = {ack, busy, nmreq, nrd, nwr, nm1, nrfsh, data_oe};
      chk("strobes", 32'(got_s), 32'(exp_s));
      if (chk_a) chk("addr", 32'(addr), 32'(ea));
      if (chk_wd) chk("data_out", 32'(data_out), 32'(t.wd));
      if (!nrfsh) chk("refresh_bit7", 32'(addr[7]), 32'd0);
      exp_d = hist.pop_front();
      hist.push_back({exp_s[5], exp_s[4], exp_s[1]});
      chk("delayed_strobes", 32'({nmreqd, nrdd, nrfshd}), 32'(exp_d));
   endtask

   always @(negedge clk) begin
      if (mon_en) mon_cycle();
   end

   task automatic release_reset();
      hist.delete();
      for (int i = 0; i < int'(DLY); i++) hist.push_back(3'b111);
      sbq.delete();
      model_r     = '0;
      model_rdata = '0;
      reset       = 1'b0;
      mon_en      = 1'b1;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the ack clock.
   task automatic run_txn(input int op, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] di, input logic [7:0] iv, input int nw);
      txn_t t;
      int   samp, last;
      t.op  = op;
      t.a   = a;
      t.wd  = wd;
      t.di  = di;
      t.iv  = iv;
      t.nw  = nw;
      t.acc = cyc + 1;
      if (op != OP_WRITE) model_rdata = di;
      t.rd = model_rdata;
      t.ra = {iv, 1'b0, model_r};
      if (op == OP_FETCH) model_r = model_r + 7'd1;
      sbq.push_back(t);

      req     = 1'b1;
      m1      = (op == OP_FETCH);
      we      = (op == OP_WRITE) ? 1'b1 : (op == OP_FETCH) ? 1'($urandom) : 1'b0;
      addr_in = a;
      wdata   = wd;
      i_reg   = iv;
      nwait   = 1'($urandom);
      data_in = 8'($urandom);
      samp    = (op == OP_FETCH) ? 2 + nw : 3 + nw;
      last    = (op == OP_FETCH) ? 4 + nw : 3 + nw;
      // Values set after edge k are sampled at edge k+1; edge 0 accepts the request.
      for (int k = 0; k < last; k++) begin
         @(posedge clk);
         @(negedge clk);
         req     = 1'($urandom);  // must be ignored while busy
         we      = 1'($urandom);
         m1      = 1'($urandom);
         addr_in = 16'($urandom);
         wdata   = 8'($urandom);
         if (k + 1 >= 2 && k + 1 <= 1 + nw) nwait = 1'b0;
         else if (k + 1 > 2 + nw || k + 1 == 1) nwait = 1'($urandom);
         else nwait = 1'b1;
         data_in = (k + 1 == samp) ? di : 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int op, nw;
      reset   = 1'b1;
      req     = 1'b0;
      we      = 1'b0;
      m1      = 1'b0;
      nwait   = 1'b1;
      addr_in = '0;
      wdata   = '0;
      i_reg   = '0;
      data_in = '0;
      repeat (3) @(negedge clk);
      release_reset();
      chk("reset_rdata", 32'(rdata), 32'd0);
      chk("reset_addr", 32'(addr), 32'd0);
      chk("reset_data_out", 32'(data_out), 32'd0);
      @(negedge clk);

      // Directed cases
      run_txn(OP_READ, 16'h1234, 8'h00, 8'hA5, 8'h00, 0);
      run_txn(OP_WRITE, 16'h8000, 8'h3C, 8'h00, 8'h00, 0);
      repeat (5) run_txn(OP_FETCH, 16'($urandom), 8'h00, 8'($urandom), 8'($urandom), 0);
      run_txn(OP_FETCH, 16'h0100, 8'h00, 8'h77, 8'h3F, 0);  // refresh addr 16'h3F05
      run_txn(OP_READ, 16'h4321, 8'h00, 8'h5A, 8'h00, 2);
      run_txn(OP_FETCH, 16'h0200, 8'h00, 8'h11, 8'h3F, 1);  // r now 6

      // Random mix, back-to-back or with short gaps
      repeat (150) begin
         op = int'($urandom_range(0, 2));
         nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_txn(op, 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), nw);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Enough fetches to wrap the refresh counter
      repeat (130) begin
         run_txn(OP_FETCH, 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(sbq.size()), 32'd0);

      // Reset asserted during T2 of a write
      mon_en  = 1'b0;
      req     = 1'b1;
      we      = 1'b1;
      m1      = 1'b0;
      addr_in = 16'h8000;
      wdata   = 8'hC3;
      nwait   = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("pre_reset_nwr", 32'(nwr), 32'd0);
      chk("pre_reset_data_oe", 32'(data_oe), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_nwr", 32'(nwr), 32'd1);
      chk("rst_nmreq", 32'(nmreq), 32'd1);
      chk("rst_data_oe", 32'(data_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_delayed", 32'({nmreqd, nrdd, nrfshd}), 32'd7);
      chk("rst_rdata", 32'(rdata), 32'd0);
      @(negedge clk);
      release_reset();
      @(negedge clk);
      // r must restart from 0 after reset
      run_txn(OP_FETCH, 16'h0300, 8'h00, 8'h99, 8'h12, 0);
      repeat (3) @(negedge clk);
      chk("queue_drained_end", 32'(sbq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
